// File: rtl/iq_pair_stream_arbiter.sv
// Serializes I/Q pairs from up to four sources onto one Avalon-ST sink as sop/eop packets.
// Define ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins arbitration instead of round-robin.
//
// state  | meaning
// IDLE   | waiting for a request; grants one source and latches its pair
// SEND_I | presenting the I beat (sop) until the sink accepts it
// SEND_Q | presenting the Q beat (eop) until the sink accepts it
// GAP    | idle spacing after eop, timed by gap_cnt
module iq_pair_stream_arbiter #(
  parameter int WIDTH      = 24,
  parameter int NUM_SRC    = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*WIDTH-1:0] src_data_i,
  input  logic [NUM_SRC*WIDTH-1:0] src_data_q,
  output logic [NUM_SRC-1:0]       src_ack,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [1:0]               out_channel,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_I = 2'd1,
    SEND_Q = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic [2:0] GAP_LOAD = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       gap_cnt;
  logic [WIDTH-1:0] q_reg;
  logic [3:0]       req_pad;
  logic [3:0]       ack_pad;
  logic [1:0]       grant_idx;
  logic [WIDTH-1:0] sel_i;
  logic [WIDTH-1:0] sel_q;

  assign req_pad = 4'(src_valid);
  assign ack_pad = 4'b0001 << grant_idx;

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    grant_idx = 2'd0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req_pad[2'(k)]) grant_idx = 2'(k);
    end
  end
`else
  logic [1:0] last_grant;
  logic [1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest set request wins.
  always_comb begin
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int off = NUM_SRC; off >= 1; off--) begin
      cand = 2'((int'(last_grant) + off) % NUM_SRC);
      if (req_pad[cand]) grant_idx = cand;
    end
  end
`endif

  always_comb begin
    sel_i = '0;
    sel_q = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant_idx == 2'(k)) begin
        sel_i = src_data_i[k*WIDTH +: WIDTH];
        sel_q = src_data_q[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|src_valid) state_nxt = SEND_I;
      SEND_I:  if (out_ready) state_nxt = SEND_Q;
      SEND_Q:  if (out_ready) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt == 3'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == SEND_I) || (state == SEND_Q);
    out_sop   = (state == SEND_I);
    out_eop   = (state == SEND_Q);
    busy      = (state != IDLE);
  end

  // out_data is loaded with I at grant and swapped to Q once the I beat is taken.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data    <= '0;
      q_reg       <= '0;
      out_channel <= 2'd0;
      src_ack     <= '0;
      gap_cnt     <= 3'd0;
`ifndef ARB_FIXED_PRIORITY_EN
      last_grant  <= 2'(NUM_SRC - 1);
`endif
    end else begin
      src_ack <= '0;
      case (state)
        IDLE: begin
          if (|src_valid) begin
            out_data    <= sel_i;
            q_reg       <= sel_q;
            out_channel <= grant_idx;
            src_ack     <= ack_pad[NUM_SRC-1:0];
`ifndef ARB_FIXED_PRIORITY_EN
            last_grant  <= grant_idx;
`endif
          end
        end
        SEND_I: if (out_ready) out_data <= q_reg;
        SEND_Q: if (out_ready) gap_cnt <= GAP_LOAD;
        GAP:    if (gap_cnt != 3'd0) gap_cnt <= gap_cnt - 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iq_pair_stream_arbiter.sv
// Randomized scoreboard bench for iq_pair_stream_arbiter; the reference model follows
// ARB_FIXED_PRIORITY_EN the same way the design does.
module tb_iq_pair_stream_arbiter;
  localparam int W   = 24;
  localparam int N   = 2;
  localparam int GAP = 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     src_valid = '0;
  logic [N*W-1:0]   src_data_i = '0;
  logic [N*W-1:0]   src_data_q = '0;
  logic [N-1:0]     src_ack;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_sop;
  logic             out_eop;
  logic [1:0]       out_channel;
  logic             busy;

  always #5 clk = ~clk;

  iq_pair_stream_arbiter #(.WIDTH(W), .NUM_SRC(N), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .src_valid(src_valid),
    .src_data_i(src_data_i), .src_data_q(src_data_q), .src_ack(src_ack),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .out_sop(out_sop), .out_eop(out_eop), .out_channel(out_channel), .busy(busy)
  );

  typedef struct {
    int           ch;
    logic [W-1:0] i;
    logic [W-1:0] q;
  } pkt_t;

  pkt_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           pkts_seen = 0;

  // Source side: what each source currently presents.
  bit           pv[N];
  logic [W-1:0] pi[N];
  logic [W-1:0] pq[N];

  // Reference model: beats still owed, gap cycles left, last winner.
  int           beats_left = 0;
  int           gap_left = 0;
  int           last_g = N - 1;
  int           inflight = -1;
  int           granted = -1;
  pkt_t         saved;
  logic [N-1:0] exp_ack = '0;
  bit           exp_busy = 1'b0;
  bit           prev_rst = 1'b1;

  bit           in_pkt = 1'b0;
  pkt_t         cur;
  bit           stall_v = 1'b0;
  logic [W+3:0] stall_snap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] reqv, input int last);
`ifdef ARB_FIXED_PRIORITY_EN
    for (int k = 0; k < N; k++) if (reqv[k]) return k;
`else
    for (int off = 1; off <= N; off++) if (reqv[(last + off) % N]) return (last + off) % N;
`endif
    return -1;
  endfunction

  task automatic new_pair(input int k);
    pv[k] = 1'b1;
    pi[k] = W'($urandom);
    pq[k] = W'($urandom);
  endtask

  task automatic drive_and_model(input bit rst, input bit rdy);
    logic [N-1:0] reqv;
    int g;
    reset_n   = !rst;
    out_ready = rdy;
    for (int k = 0; k < N; k++) begin
      src_valid[k]          = pv[k];
      src_data_i[k*W +: W]  = pi[k];
      src_data_q[k*W +: W]  = pq[k];
      reqv[k]               = pv[k];
    end
    exp_ack = '0;
    granted = -1;
    if (rst) begin
      // an aborted source keeps its pair and asks again
      if (inflight >= 0) begin
        pv[inflight] = 1'b1;
        pi[inflight] = saved.i;
        pq[inflight] = saved.q;
      end
      beats_left = 0;
      gap_left   = 0;
      last_g     = N - 1;
      inflight   = -1;
      exp_q.delete();
      exp_busy   = 1'b0;
    end else if (beats_left > 0) begin
      if (rdy) beats_left--;
      if (beats_left == 0) begin
        gap_left = GAP;
        inflight = -1;
      end
      exp_busy = (beats_left > 0) || (gap_left > 0);
    end else if (gap_left > 0) begin
      gap_left--;
      exp_busy = (gap_left > 0);
    end else begin
      g = pick(reqv, last_g);
      if (g >= 0) begin
        saved.ch = g;
        saved.i  = pi[g];
        saved.q  = pq[g];
        exp_q.push_back(saved);
        exp_ack[g] = 1'b1;
        beats_left = 2;
        last_g     = g;
        inflight   = g;
        granted    = g;
        exp_busy   = 1'b1;
      end else begin
        exp_busy = 1'b0;
      end
    end
    prev_rst = rst;
  endtask

  task automatic cycle(input bit rst, input int rdy_pct, input int req_pct,
                       input int renew_pct, input int wd_pct);
    @(posedge clk);
    #1;
    check("src_ack", 64'(src_ack), 64'(exp_ack));
    check("busy", 64'(busy), 64'(exp_busy));
    if (prev_rst)
      check("outputs_after_reset", {out_valid, out_sop, out_eop, out_channel, out_data}, '0);
    for (int k = 0; k < N; k++) begin
      if (k == granted) begin
        if ($urandom_range(99) < renew_pct) new_pair(k);
        else pv[k] = 1'b0;
      end else if (!pv[k]) begin
        if ($urandom_range(99) < req_pct) new_pair(k);
      end else if ($urandom_range(99) < wd_pct) begin
        pv[k] = 1'b0;
      end
    end
    drive_and_model(rst, $urandom_range(99) < rdy_pct);
  endtask

  // Monitor: consumes transferred beats and holds the sink side to the scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      in_pkt  = 1'b0;
      stall_v = 1'b0;
    end else begin
      if (stall_v)
        check("hold_under_backpressure", {out_valid, out_data, out_sop, out_eop, out_channel},
              {1'b1, stall_snap});
      stall_v    = out_valid && !out_ready;
      stall_snap = {out_data, out_sop, out_eop, out_channel};
      if (out_valid && out_ready) begin
        if (out_sop && !out_eop) begin
          check("sop_after_eop", 64'(in_pkt), 64'(0));
          check("packet_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("i_beat", {out_channel, out_data}, {2'(cur.ch), cur.i});
            in_pkt = 1'b1;
          end
        end else if (out_eop && !out_sop) begin
          check("eop_inside_packet", 64'(in_pkt), 64'(1));
          if (in_pkt) begin
            check("q_beat", {out_channel, out_data}, {2'(cur.ch), cur.q});
            pkts_seen++;
          end
          in_pkt = 1'b0;
        end else begin
          check("beat_flags", {out_sop, out_eop}, 2'b10);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      pv[k] = 1'b0;
      pi[k] = '0;
      pq[k] = '0;
    end
    repeat (2) cycle(1'b1, 100, 0, 0, 0);

    // single request from source 0
    pv[0] = 1'b1;
    pi[0] = 24'h000123;
    pq[0] = 24'hFFFEDC;
    repeat (8) cycle(1'b0, 100, 0, 0, 0);

    // both sources requesting continuously
    repeat (40) cycle(1'b0, 100, 100, 100, 0);

    // random backpressure with late requests
    repeat (200) cycle(1'b0, 40, 60, 50, 0);

    // reset while the Q beat is pending
    repeat (12) cycle(1'b0, 100, 0, 0, 0);
    new_pair(0);
    for (int t = 0; t < 10 && beats_left != 1; t++) cycle(1'b0, 100, 0, 0, 0);
    check("reached_send_q", 64'(beats_left), 64'(1));
    cycle(1'b1, 100, 0, 0, 0);
    repeat (8) cycle(1'b0, 100, 0, 0, 0);

    // everything mixed, including sporadic resets and withdrawals
    repeat (600) cycle($urandom_range(99) < 2, 70, 30, 40, 5);

    repeat (20) cycle(1'b0, 100, 0, 0, 0);
    @(negedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    check("no_open_packet", 64'(in_pkt), 64'(0));
    check("packets_flowed", 64'(pkts_seen > 20), 64'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
